npc_ctrl: RTL and testbench
===========================

Name: npc_ctrl

Overview:
Sequencer for the next-PC mux and the IF/ID and ID/EX pipeline registers of the 5-stage MIPS core. Arbitrates simultaneous redirect sources (exception, ERET, JR, J, branch, load-use bubble). Owns EPC, cause and the EXL bit. Runs the multi-cycle exception-entry sequence: drain, then vector to handler. Drives npc_sel / pc_we, which replace the ad-hoc PC-4 bubble flags.

Parameters:
HANDLER_ADDR, 32'h0000_1000, exception handler vector driven on npc_sel=HANDLER
DRAIN_CYCLES, 2, cycles of full flush before vectoring (1..7)
LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_pc  in  32  PC of instruction currently in ID
br_taken  in  1  branch in ID resolved taken
jump  in  1  J/JAL in ID
jr  in  1  JR in ID
eret  in  1  ERET in ID
load_use  in  1  load-use hazard detected in ID
exc_req  in  1  synchronous exception (syscall/overflow/illegal) for instruction in ID
exc_code  in  5  cause code accompanying exc_req
int_req  in  1  level external interrupt
npc_sel  out  3  0 SEQ, 1 HOLD, 2 BRANCH, 3 JUMP, 4 JR, 5 EPC, 6 HANDLER
pc_we  out  1  PC register write enable
if_id_flush  out  1  zero IF/ID this cycle
id_ex_flush  out  1  zero ID/EX this cycle
epc  out  32  exception return address
cause  out  5  latched cause code (0 = interrupt)
exl  out  1  exception level; masks exc_req/int_req
busy  out  1  high in any state other than RUN

Behaviour:
- Reset (async, rst_n=0): state RUN, npc_sel=SEQ, pc_we=1, flushes=0, epc=0, cause=0, exl=0, busy=0, counters=0. Reset mid-drain aborts the sequence immediately.
- Outputs are Moore for DRAIN/VECTOR/STALL and combinational from inputs in RUN. EPC, cause and exl are registered.
- RUN priority, highest first:
  1. exc_req & !exl: epc<=id_pc, cause<=exc_code, exl<=1. This cycle: pc_we=0, both flushes. Go to DRAIN with cnt=DRAIN_CYCLES-1.
  2. int_req & !exl: same as 1 with cause<=0.
  3. eret & exl: npc_sel=EPC, pc_we=1, if_id_flush=1, exl<=0 next edge.
  4. eret & !exl: no effect; treated as SEQ.
  5. load_use: npc_sel=HOLD, pc_we=0, id_ex_flush=1. If LU_STALL_CYCLES>1, go to STALL with cnt=LU_STALL_CYCLES-2.
  6. jr: npc_sel=JR, if_id_flush=1.
  7. jump: npc_sel=JUMP, if_id_flush=1.
  8. br_taken: npc_sel=BRANCH, if_id_flush=1.
  9. Otherwise: SEQ, pc_we=1, no flush.
- A redirect coincident with load_use is suppressed. The control instruction is re-evaluated after the bubble, so exactly one redirect occurs.
- STALL: HOLD, pc_we=0, id_ex_flush=1. Decrement cnt; at 0 return to RUN. exc_req here is deferred to RUN.
- DRAIN: pc_we=0, npc_sel=HOLD, both flushes=1. Decrement cnt; at 0 go to VECTOR. All inputs are ignored.
- VECTOR (1 cycle): npc_sel=HANDLER, pc_we=1, if_id_flush=1, then RUN.
- exc_req or int_req while exl=1: ignored; epc and cause unchanged.
- Exception entry from request to HANDLER write takes 1 + DRAIN_CYCLES + 1 cycles; with defaults, HANDLER is issued on the 4th cycle.
- cnt is 3 bits and never wraps: it loads only on state entry.

Optional Feature:
NPC_CTRL_PERF_EN
- Defined: adds outputs stall_cnt[15:0] and redirect_cnt[15:0].
  - stall_cnt increments each cycle pc_we=0.
  - redirect_cnt increments each cycle npc_sel is in {2,3,4,5,6}.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- rst_n low mid-DRAIN -> next cycle state RUN, exl=0, epc=0, pc_we=1, busy=0.
- br_taken=1 & jump=1, id_pc=0x40 -> npc_sel=3, if_id_flush=1 for exactly 1 cycle.
- load_use=1 & br_taken=1 (LU_STALL_CYCLES=1) -> cycle0 npc_sel=1, pc_we=0, id_ex_flush=1; cycle1 (load_use=0) npc_sel=2.
- exc_req, exc_code=8, id_pc=0x100 -> epc=0x100, cause=8, exl=1. Cycles 0-2 pc_we=0 with both flushes; cycle 3 npc_sel=6. A second exc_req during this sequence is ignored.
- After the handler, eret=1 with exl=1 -> npc_sel=5, epc drives 0x100, exl=0 next cycle. A second eret -> npc_sel=0.
- NPC_CTRL_PERF_EN defined: 3 load-use stalls and 2 taken branches -> stall_cnt=3, redirect_cnt=2. Force stall_cnt to 0xFFFF plus 1 stall -> stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/npc_ctrl.sv
// Next-PC sequencer: redirect arbitration, EPC/cause/EXL, exception drain/vector.
// Optional NPC_CTRL_PERF_EN adds saturating stall_cnt / redirect_cnt outputs.
module npc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR    = 32'h0000_1000,
    parameter int          DRAIN_CYCLES    = 2,
    parameter int          LU_STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_pc,
    input  logic        br_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic        eret,
    input  logic        load_use,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic        int_req,
    output logic [2:0]  npc_sel,
    output logic        pc_we,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [31:0] epc,
    output logic [4:0]  cause,
    output logic        exl,
    output logic        busy
`ifdef NPC_CTRL_PERF_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] redirect_cnt
`endif
);

    localparam logic [2:0] SEL_SEQ     = 3'd0;
    localparam logic [2:0] SEL_HOLD    = 3'd1;
    localparam logic [2:0] SEL_BRANCH  = 3'd2;
    localparam logic [2:0] SEL_JUMP    = 3'd3;
    localparam logic [2:0] SEL_JR      = 3'd4;
    localparam logic [2:0] SEL_EPC     = 3'd5;
    localparam logic [2:0] SEL_HANDLER = 3'd6;

    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);
    localparam logic [2:0] LU_INIT    =
        3'((LU_STALL_CYCLES > 1) ? (LU_STALL_CYCLES - 2) : 0);

    typedef enum logic [1:0] {
        S_RUN,
        S_STALL,
        S_DRAIN,
        S_VECTOR
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  cause_q, cause_d;
    logic        exl_q, exl_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            cnt_q   <= 3'd0;
            epc_q   <= 32'd0;
            cause_q <= 5'd0;
            exl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            exl_q   <= exl_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        exl_d       = exl_q;
        npc_sel     = SEL_SEQ;
        pc_we       = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        unique case (state_q)
            S_RUN: begin
                priority case (1'b1)
                    exc_req && !exl_q,
                    int_req && !exl_q: begin
                        epc_d       = id_pc;
                        cause_d     = (exc_req && !exl_q) ? exc_code : 5'd0;
                        exl_d       = 1'b1;
                        pc_we       = 1'b0;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        state_d     = S_DRAIN;
                        cnt_d       = DRAIN_INIT;
                    end
                    eret && exl_q: begin
                        npc_sel     = SEL_EPC;
                        if_id_flush = 1'b1;
                        exl_d       = 1'b0;
                    end
                    eret: ;
                    // Redirects under load_use are dropped; ID re-issues them after the bubble
                    load_use: begin
                        npc_sel     = SEL_HOLD;
                        pc_we       = 1'b0;
                        id_ex_flush = 1'b1;
                        if (LU_STALL_CYCLES > 1) begin
                            state_d = S_STALL;
                            cnt_d   = LU_INIT;
                        end
                    end
                    jr: begin
                        npc_sel     = SEL_JR;
                        if_id_flush = 1'b1;
                    end
                    jump: begin
                        npc_sel     = SEL_JUMP;
                        if_id_flush = 1'b1;
                    end
                    br_taken: begin
                        npc_sel     = SEL_BRANCH;
                        if_id_flush = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_STALL: begin
                npc_sel     = SEL_HOLD;
                pc_we       = 1'b0;
                id_ex_flush = 1'b1;
                if (cnt_q == 3'd0) state_d = S_RUN;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_DRAIN: begin
                npc_sel     = SEL_HOLD;
                pc_we       = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (cnt_q == 3'd0) state_d = S_VECTOR;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_VECTOR: begin
                npc_sel     = SEL_HANDLER;
                if_id_flush = 1'b1;
                state_d     = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    assign epc   = epc_q;
    assign cause = cause_q;
    assign exl   = exl_q;
    assign busy  = (state_q != S_RUN);

    logic [31:0] unused_handler;
    assign unused_handler = HANDLER_ADDR;

`ifdef NPC_CTRL_PERF_EN
    logic [15:0] stall_q;
    logic [15:0] redir_q;
    logic        redirect;

    assign redirect = npc_sel inside {SEL_BRANCH, SEL_JUMP, SEL_JR,
                                      SEL_EPC, SEL_HANDLER};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
            redir_q <= 16'd0;
        end else begin
            if (!pc_we && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
            if (redirect && redir_q != 16'hFFFF)
                redir_q <= redir_q + 16'd1;
        end
    end

    assign stall_cnt    = stall_q;
    assign redirect_cnt = redir_q;
`endif

endmodule

// File: tb/tb_npc_ctrl.sv
// Randomized and directed checks of npc_ctrl against a cycle-level
// reference model built from the redirect / exception rules.
module tb_npc_ctrl;

    localparam int DRAIN = 2;
    localparam int LU    = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_pc;
    logic        br_taken, jump, jr, eret, load_use, exc_req, int_req;
    logic [4:0]  exc_code;
    logic [2:0]  npc_sel;
    logic        pc_we, if_id_flush, id_ex_flush, exl, busy;
    logic [31:0] epc;
    logic [4:0]  cause;
`ifdef NPC_CTRL_PERF_EN
    logic [15:0] stall_cnt, redirect_cnt;
`endif

    always #5 clk = ~clk;

    npc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_pc(id_pc),
        .br_taken(br_taken), .jump(jump), .jr(jr), .eret(eret),
        .load_use(load_use), .exc_req(exc_req), .exc_code(exc_code),
        .int_req(int_req), .npc_sel(npc_sel), .pc_we(pc_we),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .epc(epc), .cause(cause), .exl(exl), .busy(busy)
`ifdef NPC_CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: remaining drain cycles, pending vector, remaining bubbles
    int          m_drain, m_stall;
    bit          m_vec, m_exl;
    logic [31:0] m_epc;
    logic [4:0]  m_cause;
    int          m_stc, m_rdc;

    task automatic model_reset();
        m_drain = 0; m_stall = 0; m_vec = 0; m_exl = 0;
        m_epc = 0; m_cause = 0; m_stc = 0; m_rdc = 0;
    endtask

    task automatic idle();
        br_taken = 0; jump = 0; jr = 0; eret = 0; load_use = 0;
        exc_req = 0; int_req = 0; exc_code = 0;
    endtask

    // inputs set at negedge by caller; checks, crosses posedge, returns at negedge
    task automatic cycle(string tag);
        logic [2:0]  es;
        bit          ew, ei, ee, eb;
        int          nd, ns;
        bit          nv, nx;
        logic [31:0] ne;
        logic [4:0]  nc;
        nd = m_drain; ns = m_stall; nv = m_vec; nx = m_exl;
        ne = m_epc; nc = m_cause;
        #1;
        es = 0; ew = 1; ei = 0; ee = 0; eb = 1;
        if (m_drain > 0) begin
            es = 1; ew = 0; ei = 1; ee = 1;
            nd = m_drain - 1;
            if (nd == 0) nv = 1;
        end else if (m_vec) begin
            es = 6; ei = 1; nv = 0;
        end else if (m_stall > 0) begin
            es = 1; ew = 0; ee = 1; ns = m_stall - 1;
        end else begin
            eb = 0;
            if ((exc_req || int_req) && !m_exl) begin
                ew = 0; ei = 1; ee = 1;
                ne = id_pc; nc = exc_req ? exc_code : 5'd0; nx = 1;
                nd = DRAIN;
            end else if (eret && m_exl) begin
                es = 5; ei = 1; nx = 0;
            end else if (eret) begin
                es = 0;
            end else if (load_use) begin
                es = 1; ew = 0; ee = 1; ns = LU - 1;
            end else if (jr) begin
                es = 4; ei = 1;
            end else if (jump) begin
                es = 3; ei = 1;
            end else if (br_taken) begin
                es = 2; ei = 1;
            end
        end
        chk({tag, ".sel"}, 32'(npc_sel), 32'(es));
        chk({tag, ".we"}, 32'(pc_we), 32'(ew));
        chk({tag, ".ifid"}, 32'(if_id_flush), 32'(ei));
        chk({tag, ".idex"}, 32'(id_ex_flush), 32'(ee));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".epc"}, epc, m_epc);
        chk({tag, ".cause"}, 32'(cause), 32'(m_cause));
        chk({tag, ".exl"}, 32'(exl), 32'(m_exl));
`ifdef NPC_CTRL_PERF_EN
        chk({tag, ".stc"}, 32'(stall_cnt), 32'(m_stc));
        chk({tag, ".rdc"}, 32'(redirect_cnt), 32'(m_rdc));
        if (!ew && m_stc < 65535) m_stc++;
        if (es >= 2 && es <= 6 && m_rdc < 65535) m_rdc++;
`endif
        @(posedge clk);
        m_drain = nd; m_stall = ns; m_vec = nv; m_exl = nx;
        m_epc = ne; m_cause = nc;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0;
        idle();
        id_pc = 0;
        model_reset();
        #12;
        chk("rst.sel", 32'(npc_sel), 0);
        chk("rst.we", 32'(pc_we), 1);
        chk("rst.busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1;

        // branch and jump together: jump wins, flush one cycle only
        id_pc = 32'h40; br_taken = 1; jump = 1;
        #1 chk("bj.sel", 32'(npc_sel), 3);
        cycle("bj");
        idle();
        cycle("bj_after");

        // load-use suppresses branch, branch re-evaluated afterwards
        load_use = 1; br_taken = 1;
        #1 chk("lu.sel", 32'(npc_sel), 1);
        cycle("lu0");
        load_use = 0;
        #1 chk("lu1.sel", 32'(npc_sel), 2);
        cycle("lu1");
        idle();

        // exception entry, second request during the sequence ignored
        id_pc = 32'h100; exc_req = 1; exc_code = 5'd8;
        cycle("exc0");
        id_pc = 32'h200; exc_code = 5'd3;
        cycle("exc1");
        cycle("exc2");
        #1 chk("exc3.sel", 32'(npc_sel), 6);
        cycle("exc3");
        idle();
        cycle("exc4");
        chk("exc.epc", epc, 32'h100);
        chk("exc.cause", 32'(cause), 8);
        chk("exc.exl", 32'(exl), 1);

        // return from handler, then a second eret is a no-op
        eret = 1;
        #1 chk("eret.sel", 32'(npc_sel), 5);
        cycle("eret0");
        chk("eret.exl", 32'(exl), 0);
        cycle("eret1");
        idle();

        // reset in the middle of the drain
        id_pc = 32'h300; exc_req = 1; exc_code = 5'd12;
        cycle("rd0");
        idle();
        cycle("rd1");
        rst_n = 0;
        #1;
        chk("rd.busy", 32'(busy), 0);
        chk("rd.we", 32'(pc_we), 1);
        chk("rd.epc", epc, 0);
        chk("rd.exl", 32'(exl), 0);
        chk("rd.sel", 32'(npc_sel), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cycle("rd2");

`ifdef NPC_CTRL_PERF_EN
        for (int i = 0; i < 3; i++) begin
            load_use = 1; cycle("pf.lu");
            load_use = 0; cycle("pf.gap");
        end
        for (int i = 0; i < 2; i++) begin
            br_taken = 1; cycle("pf.br");
        end
        idle();
        chk("pf.stall", 32'(stall_cnt), 3);
        chk("pf.redir", 32'(redirect_cnt), 2);
        force dut.stall_q = 16'hFFFF;
        #1 release dut.stall_q;
        m_stc = 65535;
        load_use = 1; cycle("pf.sat");
        load_use = 0; cycle("pf.sat1");
        chk("pf.sat", 32'(stall_cnt), 32'hFFFF);
`endif

        for (int i = 0; i < 600; i++) begin
            id_pc    = $urandom;
            exc_req  = ($urandom_range(0, 19) == 0);
            int_req  = ($urandom_range(0, 39) == 0);
            exc_code = 5'($urandom);
            eret     = ($urandom_range(0, 5) == 0);
            load_use = ($urandom_range(0, 4) == 0);
            jr       = ($urandom_range(0, 3) == 0);
            jump     = ($urandom_range(0, 3) == 0);
            br_taken = ($urandom_range(0, 3) == 0);
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
